// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter that hands the shared system bus to one of four
// masters. Grants are registered and one-cold, with at most one grant low
// per cycle. Ownership passes between masters with no idle cycle. An
// optional tenure limit (MAX_HOLD) forces rotation while others wait.
//
// Parameters
//   MAX_HOLD   : max consecutive granted cycles under contention (0..255,
//                0 disables the limit)
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   m0_req_ .. m3_req_   : active-low bus requests
//   m0_grnt_ .. m3_grnt_ : active-low registered bus grants
//   bus_owner  : index of current or last granted master (registered)
//   bus_busy_  : low while any grant is low (registered)
module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] bus_owner,
  output logic       bus_busy_
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit         LIMIT_EN = (MAX_HOLD != 0);
  // Tenure expires when the counter reaches MAX_HOLD-1, i.e. after exactly
  // MAX_HOLD granted cycles (the counter is 0 in the first granted cycle).
  localparam logic [7:0] HOLD_LIM = LIMIT_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  state_t     state;
  logic [1:0] owner;
  logic [7:0] hold_cnt;
  logic [3:0] grnt_;
  logic       busy_;

  logic [3:0] req;
  logic [3:0] others;
  logic       any_found;
  logic [1:0] any_sel;
  logic       oth_found;
  logic [1:0] oth_sel;

  // Rotating-priority search starting at last+1 and wrapping. The last
  // owner itself is considered only when incl_last is set, and then at the
  // lowest priority. Returns {found, index}.
  function automatic logic [2:0] pick_next(input logic [3:0] vec,
                                           input logic [1:0] last,
                                           input logic       incl_last);
    logic       found;
    logic [1:0] sel;
    logic [1:0] idx;
    found = 1'b0;
    sel   = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && vec[idx] && ((i < 4) || incl_last)) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  always_comb begin
    others                 = req & ~(4'b0001 << owner);
    {any_found, any_sel}   = pick_next(req, owner, 1'b1);
    {oth_found, oth_sel}   = pick_next(others, owner, 1'b0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 2'd3;
      hold_cnt <= 8'd0;
      grnt_    <= 4'b1111;
      busy_    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_found) begin
            state    <= GRANT;
            owner    <= any_sel;
            hold_cnt <= 8'd0;
            grnt_    <= ~(4'b0001 << any_sel);
            busy_    <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[owner]) begin
            // Owner released: hand straight to the next waiter, or go idle.
            if (oth_found) begin
              owner    <= oth_sel;
              hold_cnt <= 8'd0;
              grnt_    <= ~(4'b0001 << oth_sel);
            end else begin
              state    <= IDLE;
              hold_cnt <= 8'd0;
              grnt_    <= 4'b1111;
              busy_    <= 1'b1;
            end
          end else if (LIMIT_EN && (hold_cnt >= HOLD_LIM) && oth_found) begin
            // Tenure expired with someone waiting: the owner is skipped and
            // must win a later arbitration with its request still low.
            owner    <= oth_sel;
            hold_cnt <= 8'd0;
            grnt_    <= ~(4'b0001 << oth_sel);
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          grnt_    <= 4'b1111;
          busy_    <= 1'b1;
          hold_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign m0_grnt_  = grnt_[0];
  assign m1_grnt_  = grnt_[1];
  assign m2_grnt_  = grnt_[2];
  assign m3_grnt_  = grnt_[3];
  assign bus_owner = owner;
  assign bus_busy_ = busy_;

endmodule
